mag_cmp_seq: RTL and testbench

Parametrised sequential magnitude comparator: the multi-cycle, handshake-driven successor to the team's fixed 4-bit greater-than comparator. It compares two WIDTH-bit operands MSB-first, DIGIT bits per cycle, and terminates early at the first differing digit. It reports greater-than, equal and less-than, with unsigned or two's-complement interpretation selected per transaction. It sits between operand producers and control logic that need a compare result without a wide single-cycle comparator in the critical path.

---
 rtl/mag_cmp_seq.sv | 125 ++++++++++++
 tb/tb_mag_cmp_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mag_cmp_seq.sv
// Sequential magnitude comparator: MSB-first, DIGIT bits per cycle, with early exit
// at the first differing digit. Signed operands are handled by flipping the MSB on capture.
module mag_cmp_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [CW-1:0]    cnt_r;
    logic             res_valid_r;
    logic             agtb_r;
    logic             aeqb_r;
    logic             altb_r;
    logic             busy_r;

    logic [DIGIT-1:0] da_s;
    logic [DIGIT-1:0] db_s;
    logic [WIDTH-1:0] sign_flip_s;

    // Offset-binary trick: inverting both MSBs turns a signed compare into an unsigned one.
    assign sign_flip_s = {signed_mode, {(WIDTH-1){1'b0}}};
    assign da_s        = sa_r[WIDTH-1 -: DIGIT];
    assign db_s        = sb_r[WIDTH-1 -: DIGIT];

    // Ready depends only on state and reset so no combinational path exists from the handshakes.
    assign start_ready = rst_n & (state_r == IDLE);
    assign res_valid   = res_valid_r;
    assign agtb        = agtb_r;
    assign aeqb        = aeqb_r;
    assign altb        = altb_r;
    assign busy        = busy_r;

    // Control FSM, operand shift registers and registered result flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sa_r        <= {WIDTH{1'b0}};
            sb_r        <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            res_valid_r <= 1'b0;
            agtb_r      <= 1'b0;
            aeqb_r      <= 1'b0;
            altb_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        sa_r    <= a ^ sign_flip_s;
                        sb_r    <= b ^ sign_flip_s;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    if (da_s != db_s) begin
                        agtb_r      <= (da_s > db_s);
                        altb_r      <= (da_s < db_s);
                        aeqb_r      <= 1'b0;
                        res_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= DONE;
                    end else if (cnt_r == LAST_STEP) begin
                        agtb_r      <= 1'b0;
                        altb_r      <= 1'b0;
                        aeqb_r      <= 1'b1;
                        res_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= DONE;
                    end else begin
                        // busy rises one edge after accept, so a first-digit decision never shows it.
                        sa_r   <= sa_r << DIGIT;
                        sb_r   <= sb_r << DIGIT;
                        cnt_r  <= cnt_r + CW'(1);
                        busy_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        agtb_r      <= 1'b0;
                        aeqb_r      <= 1'b0;
                        altb_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    res_valid_r <= 1'b0;
                    agtb_r      <= 1'b0;
                    aeqb_r      <= 1'b0;
                    altb_r      <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Self-checking bench for mag_cmp_seq (WIDTH=8, DIGIT=2): directed cases, reset abort,
// backpressure, ignored starts, and randomized compares against an arithmetic reference.
module tb_mag_cmp_seq;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         signed_mode = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic         agtb;
    logic         aeqb;
    logic         altb;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    mag_cmp_seq #(.WIDTH(W), .DIGIT(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .signed_mode(signed_mode),
        .res_valid(res_valid), .res_ready(res_ready),
        .agtb(agtb), .aeqb(aeqb), .altb(altb), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: numeric compare of the operands as integers, {gt,eq,lt}.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
        int ix;
        int iy;
        ix = int'(x);
        iy = int'(y);
        if (sm && x[W-1]) ix = ix - (1 << W);
        if (sm && y[W-1]) iy = iy - (1 << W);
        if (ix > iy) return 3'b100;
        if (ix == iy) return 3'b010;
        return 3'b001;
    endfunction

    // Reference latency: 1-based digit index holding the highest differing bit, N if equal.
    function automatic int ref_k(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        int p;
        d = x ^ y;
        p = -1;
        for (int i = 0; i < W; i++) if (d[i]) p = i;
        if (p < 0) return N;
        return (W - 1 - p) / D + 1;
    endfunction

    task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tsm,
                           input int hold, input bit junk);
        logic [2:0] ef;
        int ek;
        int lat;
        int bcnt;
        ef = ref_flags(ta, tb_v, tsm);
        ek = ref_k(ta, tb_v);
        @(negedge clk);
        check("start_ready_idle", 32'(start_ready), 32'd1);
        a = ta;
        b = tb_v;
        signed_mode = tsm;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        signed_mode = 1'($urandom);
        lat = 0;
        bcnt = 0;
        do begin
            if (junk) begin
                start_valid = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
                signed_mode = 1'($urandom);
            end
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (!res_valid) check("flags_zero_busy", 32'({agtb, aeqb, altb}), 32'd0);
        end while (!res_valid && lat < N + 2);
        check("res_valid", 32'(res_valid), 32'd1);
        check("flags", 32'({agtb, aeqb, altb}), 32'(ef));
        check("latency", 32'(lat), 32'(ek));
        check("busy_cycles", 32'(bcnt), 32'(ek - 1));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_flags", 32'({agtb, aeqb, altb}), 32'(ef));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        start_valid = 1'b0;
        check("post_valid", 32'(res_valid), 32'd0);
        check("post_flags", 32'({agtb, aeqb, altb}), 32'd0);
        check("post_ready", 32'(start_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(start_ready), 32'd0);
        check("rst_outs", 32'({res_valid, agtb, aeqb, altb, busy}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(start_ready), 32'd1);

        // Directed cases
        run_cmp(8'hA5, 8'h25, 1'b0, 0, 1'b0);
        run_cmp(8'h5A, 8'h5B, 1'b0, 0, 1'b0);
        run_cmp(8'h5A, 8'h5A, 1'b0, 0, 1'b0);
        run_cmp(8'h80, 8'h7F, 1'b1, 0, 1'b0);
        run_cmp(8'h80, 8'h7F, 1'b0, 0, 1'b0);
        run_cmp(8'hFF, 8'hFE, 1'b1, 0, 1'b0);
        // Backpressure with ignored starts during BUSY/DONE
        run_cmp(8'h5A, 8'h5B, 1'b0, 5, 1'b1);
        run_cmp(8'h00, 8'h00, 1'b1, 5, 1'b1);

        // Reset in the middle of a long compare
        @(negedge clk);
        a = 8'h01;
        b = 8'h00;
        signed_mode = 1'b0;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_outs", 32'({res_valid, agtb, aeqb, altb, busy}), 32'd0);
        check("abort_ready", 32'(start_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_rel_ready", 32'(start_ready), 32'd1);
        repeat (N + 2) begin
            @(negedge clk);
            check("abort_no_result", 32'(res_valid), 32'd0);
        end
        run_cmp(8'h12, 8'h12, 1'b0, 0, 1'b0);

        // Randomized compares; half use a shared prefix to exercise longer latencies
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 2 == 0) rb = (ra & ~W'((1 << (2 * ($urandom % 4))) - 1)) | (rb & W'((1 << (2 * ($urandom % 4))) - 1));
            run_cmp(ra, rb, 1'($urandom), int'($urandom % 3), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
